// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed common-anode 7-segment scanner: per-digit blank gap,
// hex or raw segments, leading-zero suppression and a per-frame input snapshot.
module seg_scan_driver #(
  parameter int BLANK_CYCLES = 16,
  parameter int ON_CYCLES    = 8192,
  parameter int CNT_W        = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [3:0] raw_mask,
  input  logic [3:0] dp_mask,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_tick
);

  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             take_snap;

  logic [6:0] snap_d     [4];
  logic [6:0] snap_d_nxt [4];
  logic [3:0] snap_raw, snap_raw_nxt;
  logic [3:0] snap_dp, snap_dp_nxt;
  logic       snap_lz, snap_lz_nxt;
  logic [3:0] digit_zero;

  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;
  logic       dp_nxt;

  // Bit 7 of each digit has no meaning in either display mode.
  logic unused_msb;
  assign unused_msb = ^{d3[7], d2[7], d1[7], d0[7]};

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero when it and every digit to its left is a hex zero.
  function automatic logic lz_suppress(input logic [3:0] zero, input logic [1:0] i);
    case (i)
      2'd1:    lz_suppress = &zero[3:1];
      2'd2:    lz_suppress = &zero[3:2];
      2'd3:    lz_suppress = zero[3];
      default: lz_suppress = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state <= ST_BLANK;
      idx   <= 2'd0;
      cnt   <= BLANK_LOAD;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    take_snap = 1'b0;
    if (!enable) begin
      state_nxt = ST_BLANK;
      idx_nxt   = 2'd0;
      cnt_nxt   = BLANK_LOAD;
    end else begin
      take_snap = (state == ST_BLANK) && (idx == 2'd0) && (cnt == BLANK_LOAD);
      if (cnt == '0) begin
        if (state == ST_BLANK) begin
          state_nxt = ST_ON;
          cnt_nxt   = ON_LOAD;
        end else begin
          state_nxt = ST_BLANK;
          idx_nxt   = idx + 2'd1;
          cnt_nxt   = BLANK_LOAD;
        end
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from the next state so the registered pins line up with it.
  always_comb begin
    snap_d_nxt   = snap_d;
    snap_raw_nxt = snap_raw;
    snap_dp_nxt  = snap_dp;
    snap_lz_nxt  = snap_lz;
    if (take_snap) begin
      snap_d_nxt[0] = d0[6:0];
      snap_d_nxt[1] = d1[6:0];
      snap_d_nxt[2] = d2[6:0];
      snap_d_nxt[3] = d3[6:0];
      snap_raw_nxt  = raw_mask;
      snap_dp_nxt   = dp_mask;
      snap_lz_nxt   = blank_lz;
    end
    for (int i = 0; i < 4; i++) begin
      digit_zero[i] = !snap_raw_nxt[i] && (snap_d_nxt[i][3:0] == 4'h0);
    end
    seg_nxt = 7'h7F;
    an_nxt  = 4'hF;
    dp_nxt  = 1'b1;
    if (state_nxt == ST_ON) begin
      an_nxt = ~(4'b0001 << idx_nxt);
      dp_nxt = ~snap_dp_nxt[idx_nxt];
      if (snap_raw_nxt[idx_nxt]) begin
        seg_nxt = ~snap_d_nxt[idx_nxt];
      end else if (snap_lz_nxt && lz_suppress(digit_zero, idx_nxt)) begin
        seg_nxt = 7'h7F;
      end else begin
        seg_nxt = hex7(snap_d_nxt[idx_nxt][3:0]);
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) snap_d[i] <= 7'h00;
      snap_raw   <= 4'h0;
      snap_dp    <= 4'h0;
      snap_lz    <= 1'b0;
      seg        <= 7'h7F;
      an         <= 4'hF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      snap_d     <= snap_d_nxt;
      snap_raw   <= snap_raw_nxt;
      snap_dp    <= snap_dp_nxt;
      snap_lz    <= snap_lz_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      dp         <= dp_nxt;
      frame_tick <= take_snap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-position reference model with per-frame input
// snapshot, checked every cycle across directed and randomized scenarios.
module tb_seg_scan_driver;
  localparam int B = 2;
  localparam int O = 4;
  localparam int P = 4 * (B + O);

  logic       clkin = 1'b0;
  logic       reset, enable, blank_lz;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] raw_mask, dp_mask;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, frame_tick;

  int errors = 0;
  int checks = 0;

  // Reference model: enabled edges since the frame restarted, and the frame snapshot.
  int         s;
  logic [7:0] md [4];
  logic [3:0] mraw, mdp;
  logic       mlz;
  logic [6:0] hex_tab [16];
  logic [12:0] expv;

  seg_scan_driver #(.BLANK_CYCLES(B), .ON_CYCLES(O), .CNT_W(4)) dut (
    .clkin(clkin), .reset(reset), .enable(enable),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .raw_mask(raw_mask), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .seg(seg), .an(an), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin or posedge reset) begin
    if (reset) begin
      s = 0;
      for (int i = 0; i < 4; i++) md[i] = 8'h00;
      mraw = 4'h0; mdp = 4'h0; mlz = 1'b0;
    end else if (!enable) begin
      s = 0;
    end else begin
      if (s % P == 0) begin
        md[0] = d0; md[1] = d1; md[2] = d2; md[3] = d3;
        mraw = raw_mask; mdp = dp_mask; mlz = blank_lz;
      end
      s = s + 1;
    end
  end

  // Expected {seg, an, dp, frame_tick} from position within the frame.
  function automatic logic [12:0] model_out();
    int r, dg, ph;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic e_dp, e_tick, zeros;
    r = s % P; dg = r / (B + O); ph = r % (B + O);
    e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
    e_tick = (r == 1);
    if (ph >= B) begin
      e_an[dg] = 1'b0;
      e_dp = ~mdp[dg];
      zeros = 1'b1;
      for (int j = dg; j < 4; j++) if (mraw[j] || md[j][3:0] != 4'h0) zeros = 1'b0;
      if (mraw[dg]) e_seg = ~md[dg][6:0];
      else if (mlz && dg > 0 && zeros) e_seg = 7'h7F;
      else e_seg = hex_tab[md[dg][3:0]];
    end
    return {e_seg, e_an, e_dp, e_tick};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clkin);
    checks++;
    if ({seg, an, dp, frame_tick} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got seg=%h an=%h dp=%b tick=%b, need 7f f 1 0", seg, an, dp, frame_tick);
    end
    reset = 1'b0;
    for (int c = 0; c < 2 * P; c++) begin
      @(negedge clkin);
      expv = model_out(); checks++;
      if ({seg, an, dp, frame_tick} !== expv) begin
        errors++;
        $display("FAIL after_reset c=%0d: got %h %h %b %b, need %h", c, seg, an, dp, frame_tick, expv);
      end
    end
  endtask

  task automatic test_sequence();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < P + 2) begin @(negedge clkin); n++; end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_seen: got tick=%b, need 1 within %0d cycles", frame_tick, P + 2);
    end
    n = 0;
    do begin
      @(negedge clkin); n++;
      expv = model_out(); checks++;
      if ({seg, an, dp, frame_tick} !== expv) begin
        errors++;
        $display("FAIL sequence n=%0d: got %h %h %b %b, need %h", n, seg, an, dp, frame_tick, expv);
      end
    end while (frame_tick !== 1'b1 && n < 2 * P);
    checks++;
    if (n != P) begin
      errors++;
      $display("FAIL tick_spacing: got %0d cycles, need %0d", n, P);
    end
  endtask

  task automatic test_raw();
    int n;
    raw_mask = 4'b1100; d3 = 8'h76; d2 = 8'h79; dp_mask = 4'b0100;
    d1 = 8'($urandom); d0 = 8'($urandom);
    for (int c = 0; c < 2 * P; c++) begin
      @(negedge clkin);
      expv = model_out(); checks++;
      if ({seg, an, dp, frame_tick} !== expv) begin
        errors++;
        $display("FAIL raw c=%0d: got %h %h %b %b, need %h", c, seg, an, dp, frame_tick, expv);
      end
    end
    n = 0;
    while (an !== 4'h7 && n < P) begin @(negedge clkin); n++; end
    checks++;
    if ({an, seg, dp} !== {4'h7, 7'h09, 1'b1}) begin
      errors++;
      $display("FAIL raw_digit3: got an=%h seg=%h dp=%b, need 7 09 1", an, seg, dp);
    end
    n = 0;
    while (an !== 4'hB && n < P) begin @(negedge clkin); n++; end
    checks++;
    if ({an, seg, dp} !== {4'hB, 7'h06, 1'b0}) begin
      errors++;
      $display("FAIL raw_digit2: got an=%h seg=%h dp=%b, need b 06 0", an, seg, dp);
    end
  endtask

  task automatic test_lz();
    blank_lz = 1'b1; raw_mask = 4'h0; dp_mask = 4'h0;
    d3 = 8'h00; d2 = 8'h00; d1 = 8'h05; d0 = 8'h00;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2 * P; c++) begin
        @(negedge clkin);
        expv = model_out(); checks++;
        if ({seg, an, dp, frame_tick} !== expv) begin
          errors++;
          $display("FAIL lz%0d c=%0d: got %h %h %b %b, need %h", k, c, seg, an, dp, frame_tick, expv);
        end
      end
      raw_mask = 4'b1000;
    end
    blank_lz = 1'b0; raw_mask = 4'h0;
  endtask

  task automatic test_snapshot();
    int n;
    d0 = 8'h01; d1 = 8'h02; d2 = 8'h03; d3 = 8'h04;
    n = 0;
    while (!(s > P && (s % P) == 2 * (B + O) + B + 1) && n < 3 * P) begin @(negedge clkin); n++; end
    checks++;
    if (an !== 4'hB) begin
      errors++;
      $display("FAIL snap_reach_digit2: got an=%h, need b", an);
    end
    d0 = 8'h08;
    for (int c = 0; c < 2 * P; c++) begin
      @(negedge clkin);
      expv = model_out(); checks++;
      if ({seg, an, dp, frame_tick} !== expv) begin
        errors++;
        $display("FAIL snapshot c=%0d: got %h %h %b %b, need %h", c, seg, an, dp, frame_tick, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while ((s % P) != (B + O) + B + 1 && n < 2 * P) begin @(negedge clkin); n++; end
    checks++;
    if (an !== 4'hD) begin
      errors++;
      $display("FAIL mid_reach_digit1: got an=%h, need d", an);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({seg, an, dp, frame_tick} !== {7'h7F, 4'hF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got seg=%h an=%h dp=%b tick=%b, need 7f f 1 0", seg, an, dp, frame_tick);
    end
    @(negedge clkin);
    reset = 1'b0;
    for (int c = 0; c < P + 4; c++) begin
      @(negedge clkin);
      expv = model_out(); checks++;
      if ({seg, an, dp, frame_tick} !== expv) begin
        errors++;
        $display("FAIL post_mid_reset c=%0d: got %h %h %b %b, need %h", c, seg, an, dp, frame_tick, expv);
      end
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clkin);
      checks++;
      if ({an, frame_tick} !== {4'hF, 1'b0}) begin
        errors++;
        $display("FAIL disabled c=%0d: got an=%h tick=%b, need f 0", c, an, frame_tick);
      end
    end
    enable = 1'b1;
    @(negedge clkin);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL enable_tick: got tick=%b, need 1", frame_tick);
    end
    for (int c = 0; c < P + 2; c++) begin
      @(negedge clkin);
      expv = model_out(); checks++;
      if ({seg, an, dp, frame_tick} !== expv) begin
        errors++;
        $display("FAIL re_enable c=%0d: got %h %h %b %b, need %h", c, seg, an, dp, frame_tick, expv);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clkin);
      expv = model_out(); checks++;
      if ({seg, an, dp, frame_tick} !== expv) begin
        errors++;
        $display("FAIL random c=%0d: got %h %h %b %b, need %h", c, seg, an, dp, frame_tick, expv);
      end
      if ($urandom_range(0, 3) == 0) begin
        d0 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        d1 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        d2 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        d3 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        raw_mask = 4'($urandom); dp_mask = 4'($urandom);
        blank_lz = 1'($urandom);
      end
      enable = ($urandom_range(0, 60) != 0);
    end
    enable = 1'b1;
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset = 1'b1; enable = 1'b1; blank_lz = 1'b0;
    d0 = 8'h01; d1 = 8'h02; d2 = 8'h03; d3 = 8'h04;
    raw_mask = 4'h0; dp_mask = 4'h0;
    test_reset();
    test_sequence();
    test_raw();
    test_lz();
    test_snapshot();
    test_reset_mid();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
